// File: rtl/frame_buffer_swapper.sv
// Double-buffered 2-bit-per-pixel frame store: the renderer writes the back buffer, scan-out reads the front,
// and a swap request exchanges the buffers during vblank, clears the new back buffer, then acknowledges.
`timescale 1ns/1ps
module frame_buffer_swapper #(
   parameter int         WIDTH       = 160,
   parameter int         HEIGHT      = 144,
   parameter logic [1:0] CLEAR_COLOR = 2'b00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [1:0] color,
   input  logic       swapBuffer,
   output logic       bufferSwapped,
   input  logic       vblank,
   input  logic       rd_en,
   input  logic [7:0] rd_x,
   input  logic [7:0] rd_y,
   output logic [1:0] rd_color,
   output logic       rd_valid,
   output logic       front_sel,
   output logic       wr_dropped,
   output logic       busy
);

   localparam int            NPIX      = WIDTH * HEIGHT;
   localparam int            AW        = 15;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
   localparam logic [7:0]    W8        = 8'(WIDTH);
   localparam logic [7:0]    H8        = 8'(HEIGHT);

   typedef enum logic [2:0] {IDLE, WAIT_VBLANK, SWAP, CLEAR, DONE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] clr_cnt;
   logic [1:0]    mem0 [NPIX];
   logic [1:0]    mem1 [NPIX];

   logic          wr_in_range, rd_in_range;
   logic          pix_we, clr_we, mem_we;
   logic [AW-1:0] wr_addr, rd_addr, mem_addr;
   logic [1:0]    mem_data, rd_pix;

   assign wr_in_range = (x < W8) && (y < H8);
   assign rd_in_range = (rd_x < W8) && (rd_y < H8);
   assign wr_addr     = AW'(y) * AW'(WIDTH) + AW'(x);
   assign rd_addr     = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

   // Pixel writes and the clear sweep never overlap in time, so they share one back-buffer write port.
   assign pix_we   = wr_en && wr_in_range && (state == IDLE || state == WAIT_VBLANK);
   assign clr_we   = (state == CLEAR);
   assign mem_we   = pix_we || clr_we;
   assign mem_addr = clr_we ? clr_cnt : wr_addr;
   assign mem_data = clr_we ? CLEAR_COLOR : color;
   assign rd_pix   = front_sel ? mem1[rd_addr] : mem0[rd_addr];
   assign busy     = (state != IDLE);

   // NOTE: pixel storage has no reset; clearing 23k entries at once is neither needed nor buildable as RAM.
   always_ff @(posedge clk) begin
      if (mem_we && front_sel)  mem0[mem_addr] <= mem_data;
      if (mem_we && !front_sel) mem1[mem_addr] <= mem_data;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:        if (swapBuffer) state_nxt = WAIT_VBLANK;
         WAIT_VBLANK: begin
            if (!swapBuffer)  state_nxt = IDLE;
            else if (vblank)  state_nxt = SWAP;
         end
         SWAP:        state_nxt = CLEAR;
         CLEAR:       if (clr_cnt == LAST_ADDR) state_nxt = DONE;
         DONE:        if (!swapBuffer) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         front_sel     <= 1'b0;
         clr_cnt       <= '0;
         bufferSwapped <= 1'b0;
         wr_dropped    <= 1'b0;
      end else begin
         if (state == SWAP) begin
            front_sel <= ~front_sel;
            clr_cnt   <= '0;
         end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
         end
         // Registered so the pulse lands on the edge that writes the last cleared pixel.
         bufferSwapped <= (state == CLEAR) && (clr_cnt == LAST_ADDR);
         if (wr_en && wr_in_range && (state == SWAP || state == CLEAR))
            wr_dropped <= 1'b1;
      end
   end

   // Read path samples front_sel on the request edge, so a read on the SWAP edge sees the old front.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_valid <= 1'b0;
         rd_color <= 2'b00;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) rd_color <= rd_in_range ? rd_pix : 2'b00;
      end
   end

endmodule

// File: tb/tb_frame_buffer_swapper.sv
// Self-checking bench for frame_buffer_swapper: random pixel traffic against an array model of the two
// buffers, plus directed swap, drop, withdrawn-request and mid-clear reset scenarios.
`timescale 1ns/1ps
module tb_frame_buffer_swapper;

   localparam int         W    = 160;
   localparam int         H    = 144;
   localparam int         NPIX = W * H;
   localparam logic [1:0] CLR  = 2'b00;

   logic       clk = 1'b0;
   logic       reset, wr_en, swapBuffer, vblank, rd_en;
   logic [7:0] x, y, rd_x, rd_y;
   logic [1:0] color, rd_color;
   logic       bufferSwapped, rd_valid, front_sel, wr_dropped, busy;

   frame_buffer_swapper dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .x(x), .y(y), .color(color),
      .swapBuffer(swapBuffer), .bufferSwapped(bufferSwapped), .vblank(vblank),
      .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color), .rd_valid(rd_valid),
      .front_sel(front_sel), .wr_dropped(wr_dropped), .busy(busy)
   );

   always #5 clk = ~clk;

   int         tests  = 0;
   int         failed = 0;
   logic [1:0] mbuf   [2][NPIX];
   bit         mknown [2][NPIX];
   int         mfront = 0;
   int         wq [$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit in_rng(input int px, input int py);
      return (px < W) && (py < H);
   endfunction

   task automatic model_write(input int px, input int py, input logic [1:0] c);
      int a;
      if (in_rng(px, py)) begin
         a = py * W + px;
         mbuf[1 - mfront][a]   = c;
         mknown[1 - mfront][a] = 1'b1;
         wq.push_back(a);
      end
   endtask

   task automatic model_swap();
      mfront = 1 - mfront;
      for (int a = 0; a < NPIX; a++) begin
         mbuf[1 - mfront][a]   = CLR;
         mknown[1 - mfront][a] = 1'b1;
      end
   endtask

   task automatic do_write(input int px, input int py, input logic [1:0] c);
      wr_en = 1'b1; x = 8'(px); y = 8'(py); color = c;
      tick();
      wr_en = 1'b0;
      model_write(px, py, c);
   endtask

   task automatic do_read(input int px, input int py, input string tag);
      logic [1:0] e;
      bit         known;
      int         a;
      rd_en = 1'b1; rd_x = 8'(px); rd_y = 8'(py);
      known = 1'b1; e = 2'b00;
      if (in_rng(px, py)) begin
         a     = py * W + px;
         known = mknown[mfront][a];
         e     = mbuf[mfront][a];
      end
      tick();
      rd_en = 1'b0;
      check({tag, ".valid"}, 32'(rd_valid), 32'd1);
      if (known) check({tag, ".color"}, 32'(rd_color), 32'(e));
   endtask

   // Full swap: request, optional writes on the request and vblank edges, optional dropped write in the
   // clear sweep, optional read on the SWAP edge; the request is held `hold` cycles past the expected ack.
   task automatic run_swap(input bit wr_first, input bit wr_edge, input bit drop, input bit swap_read,
                           input int hold);
      int         lat, pulses, a;
      logic [1:0] e_sw;
      bit         k_sw;
      swapBuffer = 1'b1;
      if (wr_first) begin wr_en = 1'b1; x = 8'd5; y = 8'd3; color = 2'b10; end
      tick();
      wr_en = 1'b0;
      if (wr_first) model_write(5, 3, 2'b10);
      check("swap.busy_wait", 32'(busy), 32'd1);
      vblank = 1'b1;
      if (wr_edge) begin wr_en = 1'b1; x = 8'd7; y = 8'd9; color = 2'b01; end
      tick();
      wr_en = 1'b0; vblank = 1'b0;
      if (wr_edge) model_write(7, 9, 2'b01);
      k_sw = 1'b0; e_sw = 2'b00;
      if (swap_read) begin
         rd_en = 1'b1; rd_x = 8'd5; rd_y = 8'd3;
         a    = 3 * W + 5;
         k_sw = mknown[mfront][a];
         e_sw = mbuf[mfront][a];
      end
      lat = -1; pulses = 0;
      for (int n = 1; n <= NPIX + 1 + hold; n++) begin
         if (drop && n == 100) begin wr_en = 1'b1; x = 8'd10; y = 8'd10; color = 2'b11; end
         tick();
         wr_en = 1'b0;
         if (n == 1) begin
            check("swap.front_sel", 32'(front_sel), 32'(1 - mfront));
            if (swap_read) begin
               rd_en = 1'b0;
               check("swap_edge_read.valid", 32'(rd_valid), 32'd1);
               if (k_sw) check("swap_edge_read.color", 32'(rd_color), 32'(e_sw));
            end
         end
         if (drop && n == 100) check("drop.flag_set", 32'(wr_dropped), 32'd1);
         if (bufferSwapped) begin
            pulses++;
            if (lat < 0) lat = n;
         end
      end
      check("swap.latency", 32'(lat), 32'(NPIX + 1));
      check("swap.pulse_count", 32'(pulses), 32'd1);
      check("swap.done_held", 32'(busy), 32'd1);
      swapBuffer = 1'b0;
      tick();
      check("swap.idle_after_release", 32'(busy), 32'd0);
      model_swap();
   endtask

   initial begin
      int px, py, a;
      reset = 1'b0; wr_en = 1'b0; swapBuffer = 1'b0; vblank = 1'b0; rd_en = 1'b0;
      x = '0; y = '0; rd_x = '0; rd_y = '0; color = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.front_sel", 32'(front_sel), 32'd0);
      check("reset.bufferSwapped", 32'(bufferSwapped), 32'd0);
      check("reset.rd_valid", 32'(rd_valid), 32'd0);
      check("reset.rd_color", 32'(rd_color), 32'd0);
      check("reset.wr_dropped", 32'(wr_dropped), 32'd0);
      reset = 1'b1;
      tick();

      // Fill the back buffer: corner pixels, out-of-range writes, then random traffic.
      do_write(159, 0, 2'b01);
      do_write(0, 143, 2'b11);
      do_write(160, 0, 2'b11);
      do_write(0, 144, 2'b10);
      for (int i = 0; i < 40; i++) begin
         px = $urandom_range(0, 170);
         py = $urandom_range(0, 150);
         if ((px == 5 && py == 3) || (px == 159 && py == 0) || (px == 0 && py == 143) ||
             (px == 10 && py == 10))
            px = 200;
         do_write(px, py, 2'($urandom_range(0, 3)));
      end
      check("oor.wr_dropped", 32'(wr_dropped), 32'd0);

      // First swap: write on the request edge and on the vblank edge, dropped write during clear.
      run_swap(1'b1, 1'b1, 1'b1, 1'b0, 2000);
      check("swap1.front_sel", 32'(front_sel), 32'd1);
      do_read(5, 3, "swap1.px_5_3");
      tick();
      check("rd_valid_drop", 32'(rd_valid), 32'd0);
      do_read(7, 9, "swap1.px_7_9");
      do_read(159, 0, "swap1.px_159_0");
      do_read(0, 143, "swap1.px_0_143");
      do_read(200, 5, "oor_read");
      for (int i = 0; i < 20 && i < wq.size(); i++)
         do_read(wq[i] % W, wq[i] / W, "swap1.probe");

      // Withdrawn request: no swap happens.
      swapBuffer = 1'b1;
      tick();
      check("withdraw.busy", 32'(busy), 32'd1);
      swapBuffer = 1'b0;
      tick();
      check("withdraw.idle", 32'(busy), 32'd0);
      check("withdraw.front_sel", 32'(front_sel), 32'd1);
      check("withdraw.no_pulse", 32'(bufferSwapped), 32'd0);

      for (int i = 0; i < 30; i++) begin
         px = $urandom_range(0, W - 1);
         py = $urandom_range(0, H - 1);
         if ((px == 5 && py == 3) || (px == 10 && py == 10)) px = 20;
         do_write(px, py, 2'($urandom_range(0, 3)));
      end

      // Second swap with a read on the SWAP edge.
      run_swap(1'b0, 1'b0, 1'b0, 1'b1, 5);
      check("swap2.front_sel", 32'(front_sel), 32'd0);
      do_read(5, 3, "swap2.cleared_5_3");
      do_read(10, 10, "swap2.dropped_10_10");
      for (int i = 0; i < 20; i++)
         do_read($urandom_range(0, 165), $urandom_range(0, 148), "swap2.rand");
      check("drop.sticky", 32'(wr_dropped), 32'd1);

      // Reset in the middle of a clear sweep.
      swapBuffer = 1'b1;
      tick();
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      repeat (1000) tick();
      check("midclear.busy", 32'(busy), 32'd1);
      check("midclear.front_sel", 32'(front_sel), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset.busy", 32'(busy), 32'd0);
      check("async_reset.front_sel", 32'(front_sel), 32'd0);
      check("async_reset.bufferSwapped", 32'(bufferSwapped), 32'd0);
      check("async_reset.wr_dropped", 32'(wr_dropped), 32'd0);
      mfront = 0;
      for (int i = 0; i < NPIX; i++) mknown[0][i] = 1'b0;
      swapBuffer = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("post_reset.no_pulse", 32'(bufferSwapped), 32'd0);

      // A fresh swap completes normally after the aborted one.
      do_write(33, 44, 2'b11);
      do_write(150, 140, 2'b10);
      run_swap(1'b0, 1'b0, 1'b0, 1'b0, 3);
      check("swap4.front_sel", 32'(front_sel), 32'd1);
      do_read(33, 44, "swap4.px_33_44");
      do_read(150, 140, "swap4.px_150_140");
      for (int i = 0; i < 15; i++)
         do_read($urandom_range(0, W - 1), $urandom_range(0, H - 1), "swap4.rand");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
